// File: rtl/mac_block_param.sv
// Parametrised two-stage unsigned MAC: lane products are combined per mode, then either
// emitted directly or accumulated onto a group start value, with valid/ready flow control.
module mac_block_param #(
   parameter int unsigned MIN_WIDTH = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned ACC_WIDTH = 48
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*MIN_WIDTH-1:0] a,
   input  logic [MIN_WIDTH-1:0]       b,
   input  logic [1:0]                 mode,
   input  logic                       acc_en,
   input  logic                       acc_first,
   input  logic                       acc_last,
   input  logic [ACC_WIDTH-1:0]       init_val,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_WIDTH-1:0]       c,
   output logic                       ovf
);

   localparam int unsigned PW = 2 * MIN_WIDTH;

   logic                 adv;
   logic [ACC_WIDTH-1:0] term [LANES];
   int unsigned          need;
   logic [ACC_WIDTH-1:0] sum;

   // Stage 1 registers
   logic                 s1_valid;
   logic [ACC_WIDTH-1:0] s1_sum;
   logic                 s1_acc_en;
   logic                 s1_first;
   logic                 s1_last;
   logic [ACC_WIDTH-1:0] s1_init;

   // Stage 2 accumulator state
   logic [ACC_WIDTH-1:0] acc_q;
   logic                 sticky_q;
   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic                 carry;
   logic                 sticky_next;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;

   // Products are truncated to ACC_WIDTH before shifting; the sum is taken modulo 2^ACC_WIDTH
   // anyway, so dropping high bits early gives the same result.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [PW-1:0] prod;
      assign prod    = PW'(a[i*MIN_WIDTH +: MIN_WIDTH]) * PW'(b);
      assign term[i] = ACC_WIDTH'(prod) << (i * MIN_WIDTH);
   end

   always_comb begin
      need = 0;
      case (mode)
         2'd0:    need = 1;
         2'd1:    need = 2;
         2'd2:    need = 4;
         default: need = 0;
      endcase
      sum = '0;
      // Reserved mode or a mode wider than the instantiated lanes yields zero.
      if (need != 0 && need <= LANES) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (i < need) begin
               sum = sum + term[i];
            end
         end
      end
   end

   always_comb begin
      acc_base         = s1_first ? s1_init : acc_q;
      {carry, acc_sum} = {1'b0, acc_base} + {1'b0, s1_sum};
      sticky_next      = (s1_first ? 1'b0 : sticky_q) | carry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_acc_en <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_init   <= '0;
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         c         <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sum    <= sum;
            s1_acc_en <= acc_en;
            s1_first  <= acc_first;
            s1_last   <= acc_last;
            s1_init   <= init_val;
         end
         // Either the slot was empty or its result is being consumed on this edge.
         out_valid <= 1'b0;
         if (s1_valid) begin
            if (!s1_acc_en) begin
               c         <= s1_sum;
               ovf       <= 1'b0;
               out_valid <= 1'b1;
            end else begin
               acc_q    <= acc_sum;
               sticky_q <= sticky_next;
               if (s1_last) begin
                  c         <= acc_sum;
                  ovf       <= sticky_next;
                  out_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/mac_block_param.md
# mac_block_param

Parametrised, pipelined successor to the fixed-width MAC block. It multiplies one B sub-word against up to LANES A sub-words and combines the shifted partial products according to mode. It either emits each product or accumulates a group of products onto an initial value. Valid/ready handshakes on input and output allow it to sit in a stallable fabric datapath.

## Interface
- MIN_WIDTH, 8: sub-word width in bits.
- LANES, 4: number of A sub-words; must be 1, 2 or 4.
- ACC_WIDTH, 48: accumulator and output width; must be ≥ 2*MIN_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  LANES*MIN_WIDTH  A sub-words; lane i is a[i*MIN_WIDTH +: MIN_WIDTH].
- b  in  MIN_WIDTH  shared B operand.
- mode  in  2  0 single, 1 dual, 2 quad, 3 reserved.
- acc_en  in  1  1 = accumulate beat, 0 = multiply-only beat.
- acc_first  in  1  accumulate beat starts a group; load init_val.
- acc_last  in  1  accumulate beat ends a group; emit the result.
- init_val  in  ACC_WIDTH  group start value, sampled on an acc_first beat.
- out_valid  out  1  c/ovf valid.
- out_ready  in  1  downstream accepts the output.
- c  out  ACC_WIDTH  result.
- ovf  out  1  sticky carry-out for the emitted result.

## Operation
- A beat is accepted when in_valid && in_ready.
- All arithmetic is unsigned. Product p_i = a_lane_i * b, which is 2*MIN_WIDTH bits.
- sum for each mode:
  - Single: p_0.
  - Dual: p_0 + (p_1 << MIN_WIDTH).
  - Quad: Σ p_i << (i*MIN_WIDTH) for i = 0..3.
  - Reserved mode, or a mode needing more lanes than LANES: sum = 0. The beat still flows through the pipeline.
- sum is zero-extended to ACC_WIDTH. Bits above ACC_WIDTH are dropped.
- Stage 1 registers sum plus the control bits (acc_en, acc_first, acc_last, init_val).
- Stage 2 processes a multiply-only beat as follows:
  - c <= sum, ovf <= 0, out_valid <= 1.
  - The internal accumulator register acc is not touched.
- Stage 2 processes an accumulate beat as follows:
  - acc <= (acc_first ? init_val : acc) + sum, modulo 2^ACC_WIDTH.
  - Carry-out of that add sets an internal sticky flag. acc_first clears the flag before the add.
  - If acc_last: c <= new acc, ovf <= new sticky, out_valid <= 1. Otherwise out_valid is not raised.
- An accumulate beat without a preceding acc_first adds onto the current acc, which is 0 after reset.
- acc_first && acc_last on one beat gives c = init_val + sum.
- Multiply-only beats may be interleaved inside an accumulation group. The group's acc and sticky flag are preserved.
- mode may change between beats of one group.

## Timing
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv && !rst.
- Stage 1 and stage 2 advance only when adv = 1. When adv = 0, all registers hold and c/ovf stay stable.
- out_valid drops on the edge where out_valid && out_ready, unless a new result is loaded on that same edge.
- Latency: a beat accepted at edge k gives a result registered at edge k+1. out_valid is high after edge k+1, i.e. 2 cycles after the accept cycle.
- Throughput is one beat per cycle with out_ready held high. Output order equals input order.
- Reset, including mid-group or mid-stall:
  - Stage 1 valid = 0, out_valid = 0, c = 0, ovf = 0, acc = 0, sticky = 0.
  - in_ready = 0 while rst is high.
  - In-flight beats are discarded.

## Test plan
- Single beat: mode 0, lane0 = 0xFF, b = 0xFF, acc_en = 0 → out_valid 2 cycles later, c = 0xFE01, ovf = 0.
- Quad beat: lanes3..0 = 0x04, 0x03, 0x02, 0x01, b = 0x10 → c = 0x40302010.
- Accumulate group: 4 dual beats with lane1 = 0, lane0 = 1, b = 5, init_val = 100. first on beat 1, last on beat 4 → exactly one out_valid, c = 120. A multiply-only beat inserted mid-group → c = 5 for that beat, group result still 120.
- Backpressure: stream 6 single beats (lane0 = 1..6, b = 2) with out_ready low for 3 cycles mid-stream → in_ready low while stalled, c held stable, outputs received in order 2, 4, …, 12 with none lost or duplicated.
- Overflow: init_val = 2^48−1, single beat 1*1 with first && last → c = 0, ovf = 1. Next group with first, init_val = 0, beat 1*1 → c = 1, ovf = 0.
- Reset mid-group: 2 accumulate beats, assert rst 1 cycle, then a first && last beat with init_val = 0, 3*3 → out_valid = 0 and c = 0 during reset; next result c = 9.
